io_bus_arbiter: RTL

//  Two-master arbiter sharing the J1 peripheral I/O bus (rd/wr/addr/data) between

---
 rtl/io_bus_arbiter_pkg.sv | 17 +
 rtl/io_bus_arbiter_rr_arbiter2.sv | 25 ++
 rtl/io_bus_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the two-master J1 peripheral I/O bus arbiter.
package io_bus_arbiter_pkg;

    localparam int IO_W = 16;

    // Master index constants; also the encoding of the owner / grant registers.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// master that was not granted last.
module rr_arbiter2
    import io_bus_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    // Combinational winner selection from the current requests and grant history.
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end else if (req1) begin
            grant_idx = M1;
        end else begin
            grant_idx = M0;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbiter sharing the J1 peripheral I/O bus between the CPU-side bridge (m0)
// and the DMA/loader engine (m1). One transaction at a time: a single-cycle
// io_rd/io_wr strobe, optional read wait, then a one-cycle ack to the owner.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [IO_W-1:0] m0_addr,
    input  logic [IO_W-1:0] m0_wdata,
    output logic            m0_ack,
    output logic [IO_W-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [IO_W-1:0] m1_addr,
    input  logic [IO_W-1:0] m1_wdata,
    output logic            m1_ack,
    output logic [IO_W-1:0] m1_rdata,
    output logic            io_rd,
    output logic            io_wr,
    output logic [IO_W-1:0] io_addr,
    output logic [IO_W-1:0] io_dout,
    input  logic [IO_W-1:0] io_din,
    output logic            busy
);

    // Wait-counter preload: WAIT lasts RD_LATENCY cycles, counting down to zero.
    localparam logic [2:0] LAT_INIT = (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       we_r;
    logic       last_grant;
    logic [2:0] lat_cnt;
    logic       capture;
    logic       grant_valid;
    logic       grant_idx;

    rr_arbiter2 u_rr (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next-state decode and read-data capture strobe for the transaction FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (we_r) begin
                    state_nxt = ACK;
                end else if (RD_LATENCY == 0) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM register, read-latency counter and round-robin history.
    always_ff @(posedge sys_clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, regardless of statement order.
        if (sys_rst_i) begin
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            last_grant <= M1;
        end else begin
            state <= state_nxt;
            if (state == ISSUE) begin
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT && lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (state == ACK) last_grant <= owner;
        end
    end

    // Datapath: latch the winner's request in IDLE, steer captured read data to the owner.
    always_ff @(posedge sys_clk_i) begin
        // NOTE: these are architectural outputs that must read 0 after reset, so they are reset like control state.
        if (sys_rst_i) begin
            owner    <= M0;
            we_r     <= 1'b0;
            io_addr  <= '0;
            io_dout  <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                owner   <= grant_idx;
                we_r    <= (grant_idx == M1) ? m1_we    : m0_we;
                io_addr <= (grant_idx == M1) ? m1_addr  : m0_addr;
                io_dout <= (grant_idx == M1) ? m1_wdata : m0_wdata;
            end
            if (capture) begin
                if (owner == M1) m1_rdata <= io_din;
                else             m0_rdata <= io_din;
            end
        end
    end

    // Strobes and acks are pure decodes of the registered state, so reset clears them at once.
    assign io_wr  = (state == ISSUE) &&  we_r;
    assign io_rd  = (state == ISSUE) && !we_r;
    assign m0_ack = (state == ACK) && (owner == M0);
    assign m1_ack = (state == ACK) && (owner == M1);
    assign busy   = (state != IDLE);

endmodule
